alu_unit: RTL
=============

// Module: alu_unit
// PURPOSE
//   Execution end of the RS->ALU issue interface. Accepts at most one ready op per
//   cycle from the reservation station (no backpressure; RS issues whenever an entry
//   is ready). Computes an RV32I integer or branch-compare result, then broadcasts
//   {valid, value, rob_id} on the ALU CDB port. The RS, LSB and ROB snoop that port.
//   Pipeline depth is 1 or 2 register stages.
// PARAMETERS
//   TYPE_W      4   width of arith_type (matches RS_TYPE_BIT)
//   ROB_W       3   width of ROB id (matches ROB_SIZE_BIT)
//   PIPE_STAGES 1   1: result registered once; 2: operand stage + result stage
// PORTS
//   clk_in        in   1      system clock
//   rst_in        in   1      asynchronous reset, active-low
//   rdy_in        in   1      global ready; low freezes all state
//   rob_clear     in   1      flush (mispredict); kills every in-flight op
//   alu_input     in   1      issue valid from RS
//   arith_type    in   TYPE_W op select (table below)
//   alu_r1_val    in   32     operand A (rs1)
//   alu_r2_val    in   32     operand B (rs2 or imm)
//   inst_rob_id   in   ROB_W  ROB id of issued op
//   alu_fi        out  1      CDB valid; one-cycle pulse per completed op
//   alu_value     out  32     CDB result
//   alu_rob_id    out  ROB_W  CDB ROB id
// BEHAVIOUR
//   - Op table (type: result):
//       0 ADD a+b          1 SUB a-b          2 AND             3 OR
//       4 XOR              5 SLL a<<b[4:0]    6 SRL logical     7 SRA arithmetic
//       8 SLT signed       9 SLTU unsigned
//       10 EQ  11 NE  12 LT  13 GE  14 LTU  15 GEU
//   - Types 8..15 return a 32-bit value of 0 or 1.
//   - Add/sub wrap mod 2^32; no overflow flag. Shifts use b[4:0] only.
//   - Reset (rst_in=0, async): every stage valid=0, alu_fi=0, alu_value=0, alu_rob_id=0.
//   - Stage k holds {valid, type/value, a, b, rob_id}.
//   - PIPE_STAGES=1: issue at edge N -> alu_fi=1 with the result during cycle N+1.
//   - PIPE_STAGES=2: operands registered at edge N -> result registered at N+1
//     -> alu_fi=1 during cycle N+2.
//   - Throughput is 1 op/cycle in both modes; back-to-back issues give back-to-back alu_fi.
//   - alu_input=0 at an edge writes valid=0 into the first stage (a bubble).
//     Data fields of a bubble are don't-care; alu_fi is still 0.
//   - rdy_in=0: all registers hold. alu_input that cycle is ignored; RS also freezes,
//     so nothing is lost. alu_fi stays at its held value, and CDB consumers gate on
//     rdy_in themselves.
//   - rob_clear=1 with rdy_in=1 at an edge: every stage valid<=0 and alu_fi<=0.
//     An issue in the same cycle is discarded; clear has priority over issue.
//   - rob_clear=1 with rdy_in=0: no effect (the clear is ignored).
//   - Reset asserted mid-operation: in-flight ops are dropped immediately (async).
//     No partial broadcast occurs after reset release.
//   - Result is a pure function of the registered {type, a, b}. There are no
//     internal hazards and no forwarding.
//   - alu_rob_id equals the issued inst_rob_id, delayed by PIPE_STAGES cycles.
// TESTING
//   1 ADD: a=0xFFFFFFFF, b=1, rob=5 -> next cycle alu_fi=1, value=0, rob_id=5;
//     the cycle after, alu_fi=0.
//   2 SRA/SRL: a=0x80000000, b=0x21 (shift 1) -> SRA gives 0xC0000000;
//     SRL gives 0x40000000.
//   3 Compares: a=0xFFFFFFFF, b=1 -> SLT=1, SLTU=0, LT=1, GEU=1, EQ=0, NE=1.
//   4 Back-to-back: issue rob 1,2,3 on consecutive edges with PIPE_STAGES=2
//     -> alu_fi high for 3 consecutive cycles starting 2 cycles after the first
//     issue, ids 1,2,3 in order.
//   5 Flush: issue rob 4, then rob_clear=1 together with issue rob 6
//     -> no alu_fi for 4 or 6; the next op after the clear broadcasts normally.
//   6 Stall/reset: rdy_in=0 for 3 cycles with an op in flight -> outputs frozen,
//     and the op broadcasts exactly once after rdy_in returns. Pulse rst_in low
//     mid-flight -> alu_fi=0 immediately and no broadcast afterwards.

Source files
------------

// File: rtl/alu_unit.sv
// ---------------------------------------------------------------------------
// alu_unit
//   Execution end of the RS->ALU issue path. Takes at most one ready op per
//   cycle from the reservation station, evaluates an RV32I integer or
//   branch-compare operation, and broadcasts {valid, value, rob_id} on the
//   ALU CDB port. The latency is PIPE_STAGES register stages (1 or 2).
//   Throughput is one op per cycle in either mode.
//
// Parameters
//   TYPE_W      width of arith_type (op select)
//   ROB_W       width of the ROB id
//   PIPE_STAGES 1: result registered once
//               2: operand stage followed by result stage
//
// Ports
//   clk_in       in   1       system clock
//   rst_in       in   1       asynchronous reset, active-low
//   rdy_in       in   1       global ready; low freezes every register
//   rob_clear    in   1       flush; kills every in-flight op (needs rdy_in)
//   alu_input    in   1       issue valid from the RS
//   arith_type   in   TYPE_W  op select
//   alu_r1_val   in   32      operand A (rs1)
//   alu_r2_val   in   32      operand B (rs2 or immediate)
//   inst_rob_id  in   ROB_W   ROB id of the issued op
//   alu_fi       out  1       CDB valid, one pulse per completed op
//   alu_value    out  32      CDB result
//   alu_rob_id   out  ROB_W   CDB ROB id
// ---------------------------------------------------------------------------
module alu_unit #(
  parameter int TYPE_W      = 4,
  parameter int ROB_W       = 3,
  parameter int PIPE_STAGES = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rob_clear,
  input  logic              alu_input,
  input  logic [TYPE_W-1:0] arith_type,
  input  logic [31:0]       alu_r1_val,
  input  logic [31:0]       alu_r2_val,
  input  logic [ROB_W-1:0]  inst_rob_id,
  output logic              alu_fi,
  output logic [31:0]       alu_value,
  output logic [ROB_W-1:0]  alu_rob_id
);

  localparam int DATA_W = 32;

  localparam logic [TYPE_W-1:0] OP_ADD  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] OP_SUB  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] OP_AND  = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] OP_OR   = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] OP_XOR  = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] OP_SLL  = TYPE_W'(5);
  localparam logic [TYPE_W-1:0] OP_SRL  = TYPE_W'(6);
  localparam logic [TYPE_W-1:0] OP_SRA  = TYPE_W'(7);
  localparam logic [TYPE_W-1:0] OP_SLT  = TYPE_W'(8);
  localparam logic [TYPE_W-1:0] OP_SLTU = TYPE_W'(9);
  localparam logic [TYPE_W-1:0] OP_EQ   = TYPE_W'(10);
  localparam logic [TYPE_W-1:0] OP_NE   = TYPE_W'(11);
  localparam logic [TYPE_W-1:0] OP_LT   = TYPE_W'(12);
  localparam logic [TYPE_W-1:0] OP_GE   = TYPE_W'(13);
  localparam logic [TYPE_W-1:0] OP_LTU  = TYPE_W'(14);
  localparam logic [TYPE_W-1:0] OP_GEU  = TYPE_W'(15);

  // Pure combinational evaluation of one op. Add/sub wrap; shifts use only
  // the low five bits of b; compare-type ops return 0 or 1.
  function automatic logic [DATA_W-1:0] alu_calc(
    input logic [TYPE_W-1:0] op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic        [4:0]        sh;
    logic        [DATA_W-1:0] r;
    sa = a;
    sb = b;
    sh = b[4:0];
    r  = '0;
    case (op)
      OP_ADD:        r = a + b;
      OP_SUB:        r = a - b;
      OP_AND:        r = a & b;
      OP_OR:         r = a | b;
      OP_XOR:        r = a ^ b;
      OP_SLL:        r = a << sh;
      OP_SRL:        r = a >> sh;
      OP_SRA:        r = sa >>> sh;
      OP_SLT, OP_LT: r = DATA_W'(sa < sb);
      OP_SLTU,
      OP_LTU:        r = DATA_W'(a < b);
      OP_EQ:         r = DATA_W'(a == b);
      OP_NE:         r = DATA_W'(a != b);
      OP_GE:         r = DATA_W'(!(sa < sb));
      OP_GEU:        r = DATA_W'(!(a < b));
      default:       r = '0;
    endcase
    return r;
  endfunction

  // Operands feeding the result stage: either straight from the issue port
  // or from the optional operand register stage.
  logic              src_vld;
  logic [TYPE_W-1:0] src_type;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [ROB_W-1:0]  src_rob;

  generate
    if (PIPE_STAGES == 2) begin : g_op_stage
      logic              vld_p0;
      logic [TYPE_W-1:0] type_p0;
      logic [DATA_W-1:0] a_p0;
      logic [DATA_W-1:0] b_p0;
      logic [ROB_W-1:0]  rob_p0;

      // ---- stage p0: operand capture ----
      // A clear in the same cycle as an issue wins: the issue is dropped.
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          vld_p0 <= 1'b0;
        end else if (rdy_in) begin
          vld_p0 <= alu_input & ~rob_clear;
        end
      end

      // Payload of a bubble is don't-care, so only load on a real issue.
      always_ff @(posedge clk_in) begin
        if (rdy_in && alu_input) begin
          type_p0 <= arith_type;
          a_p0    <= alu_r1_val;
          b_p0    <= alu_r2_val;
          rob_p0  <= inst_rob_id;
        end
      end

      assign src_vld  = vld_p0;
      assign src_type = type_p0;
      assign src_a    = a_p0;
      assign src_b    = b_p0;
      assign src_rob  = rob_p0;
    end else begin : g_direct
      assign src_vld  = alu_input;
      assign src_type = arith_type;
      assign src_a    = alu_r1_val;
      assign src_b    = alu_r2_val;
      assign src_rob  = inst_rob_id;
    end
  endgenerate

  logic [DATA_W-1:0] result_p0;
  assign result_p0 = alu_calc(src_type, src_a, src_b);

  logic              vld_p1;
  logic [DATA_W-1:0] value_p1;
  logic [ROB_W-1:0]  rob_p1;

  // ---- stage p1: result / CDB register ----
  // The CDB payload is reset because consumers may look at it while idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      vld_p1   <= 1'b0;
      value_p1 <= '0;
      rob_p1   <= '0;
    end else if (rdy_in) begin
      vld_p1   <= src_vld & ~rob_clear;
      value_p1 <= result_p0;
      rob_p1   <= src_rob;
    end
  end

  assign alu_fi     = vld_p1;
  assign alu_value  = value_p1;
  assign alu_rob_id = rob_p1;

endmodule
